// File: rtl/board_rev1_reset_seq_pkg.sv
// Shared board definitions: sequencer states, parameter defaults and the
// saturating loss-counter helper.
package board_rev1_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_MEM,
    ST_GAP_MEM,
    ST_WAIT_TMDS,
    ST_GAP_TMDS,
    ST_RUN
  } seq_state_e;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int STEP_CYCLES_DEF   = 16;

  localparam int              LOSS_W   = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  // Lock-loss events stop counting at all-ones instead of wrapping.
  function automatic logic [LOSS_W-1:0] loss_inc(input logic [LOSS_W-1:0] v);
    return (v == LOSS_MAX) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/board_rev1_reset_seq_if.sv
// Lock/ready bundle between the board clock block and the reset sequencer.
// master = clock-block side (drives locks), slave = sequencer side.
interface board_rev1_reset_seq_if;
  import board_rev1_reset_seq_pkg::*;

  logic              MEM_LOCK;
  logic              TMDS_LOCK;
  logic              MEM_RESET_n;
  logic              TMDS_RESET_n;
  logic              SYS_RESET_n;
  logic              READY;
  logic [LOSS_W-1:0] LOSS_COUNT;

  modport master (
    output MEM_LOCK, TMDS_LOCK,
    input  MEM_RESET_n, TMDS_RESET_n, SYS_RESET_n, READY, LOSS_COUNT
  );

  modport slave (
    input  MEM_LOCK, TMDS_LOCK,
    output MEM_RESET_n, TMDS_RESET_n, SYS_RESET_n, READY, LOSS_COUNT
  );

endinterface

// File: rtl/board_lock_qualifier.sv
// Brings one asynchronous PLL lock into the CLK domain and flags it stable
// once it has stayed high for STABLE_CYCLES consecutive cycles.
module board_lock_qualifier
  import board_rev1_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock,
  output logic lock_s,
  output logic stable
);

  localparam int              CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  // Shift the raw lock in; any low synchronized sample restarts the count.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], lock};
    cnt_d  = '0;
    if (sync_q[SYNC_STAGES-1])
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  end

  // Synchronizer and stability counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign stable = (cnt_q == CntMax);

endmodule

// File: rtl/board_rev1_reset_seq.sv
// Board reset sequencer: qualifies the MEM and TMDS PLL locks, then releases
// MEM, TMDS and SYS resets in order with guard gaps, re-sequencing on loss.
module board_rev1_reset_seq
  import board_rev1_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int STEP_CYCLES   = STEP_CYCLES_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  board_rev1_reset_seq_if.slave bus
);

  localparam int StepW = $clog2(STEP_CYCLES + 1);
  // The pass through ST_WAIT_TMDS costs one edge, so the MEM gap exits one
  // edge early to keep MEM->TMDS release spacing at STEP_CYCLES.
  localparam logic [StepW-1:0] GapMemLast  =
    StepW'((STEP_CYCLES >= 2) ? STEP_CYCLES - 2 : 0);
  localparam logic [StepW-1:0] GapTmdsLast = StepW'(STEP_CYCLES - 1);

  logic mem_lock_s, mem_stable, tmds_lock_s, tmds_stable;

  board_lock_qualifier #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_mem_q (
    .clk   (CLK),
    .rst_n (RESET_n),
    .lock  (bus.MEM_LOCK),
    .lock_s(mem_lock_s),
    .stable(mem_stable)
  );

  board_lock_qualifier #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_tmds_q (
    .clk   (CLK),
    .rst_n (RESET_n),
    .lock  (bus.TMDS_LOCK),
    .lock_s(tmds_lock_s),
    .stable(tmds_stable)
  );

  seq_state_e        state_q, state_d;
  logic [StepW-1:0]  step_q, step_d;
  logic              mem_rst_q, mem_rst_d;
  logic              tmds_rst_q, tmds_rst_d;
  logic              sys_rst_q, sys_rst_d;
  logic              ready_q, ready_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              mem_loss, tmds_loss;

  assign mem_loss  = (state_q != ST_WAIT_MEM) && !mem_lock_s;
  assign tmds_loss = ((state_q == ST_GAP_TMDS) || (state_q == ST_RUN)) && !tmds_lock_s;

  // Next state and outputs; MEM loss dominates TMDS loss dominates sequencing.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mem_rst_d  = mem_rst_q;
    tmds_rst_d = tmds_rst_q;
    sys_rst_d  = sys_rst_q;
    ready_d    = ready_q;
    loss_d     = loss_q;
    if (mem_loss) begin
      state_d    = ST_WAIT_MEM;
      mem_rst_d  = 1'b0;
      tmds_rst_d = 1'b0;
      sys_rst_d  = 1'b0;
      ready_d    = 1'b0;
      loss_d     = loss_inc(loss_q);
    end else if (tmds_loss) begin
      // System core keeps running through a video PLL drop.
      state_d    = ST_WAIT_TMDS;
      tmds_rst_d = 1'b0;
      ready_d    = 1'b0;
      loss_d     = loss_inc(loss_q);
    end else begin
      case (state_q)
        ST_WAIT_MEM: begin
          if (mem_stable) begin
            mem_rst_d = 1'b1;
            state_d   = ST_GAP_MEM;
          end
        end
        ST_GAP_MEM: begin
          if (step_q == GapMemLast) state_d = ST_WAIT_TMDS;
          else                      step_d  = step_q + StepW'(1);
        end
        ST_WAIT_TMDS: begin
          if (tmds_stable) begin
            tmds_rst_d = 1'b1;
            state_d    = ST_GAP_TMDS;
          end
        end
        ST_GAP_TMDS: begin
          if (step_q == GapTmdsLast) begin
            sys_rst_d = 1'b1;
            ready_d   = 1'b1;
            state_d   = ST_RUN;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        ST_RUN: begin
        end
        default: state_d = ST_WAIT_MEM;
      endcase
    end
    if (state_d != state_q) step_d = '0;
  end

  // State and output registers; RESET_n overrides every event on its edge.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q    <= ST_WAIT_MEM;
      step_q     <= '0;
      mem_rst_q  <= 1'b0;
      tmds_rst_q <= 1'b0;
      sys_rst_q  <= 1'b0;
      ready_q    <= 1'b0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mem_rst_q  <= mem_rst_d;
      tmds_rst_q <= tmds_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      loss_q     <= loss_d;
    end
  end

  assign bus.MEM_RESET_n  = mem_rst_q;
  assign bus.TMDS_RESET_n = tmds_rst_q;
  assign bus.SYS_RESET_n  = sys_rst_q;
  assign bus.READY        = ready_q;
  assign bus.LOSS_COUNT   = loss_q;

endmodule
